avmm_csr_master: RTL
====================

AVMM_CSR_MASTER -- requirements
Module: avmm_csr_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd255, meaning the maximum cycles spent in REQ plus RD_WAIT per transaction (legal 1..65535).
REQ-002 SHALL have parameter TIMEOUT_DATA, default 32'hDEAD_BEEF, meaning the rsp_rdata value returned on a read timeout.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accept.
REQ-007 cmd_write  input  1  1=write, 0=read.
REQ-008 cmd_addr  input  32  CSR byte address.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed.
REQ-012 rsp_rdata  output  32  read data (0 for writes).
REQ-013 rsp_write  output  1  echo of cmd_write.
REQ-014 rsp_timeout  output  1  transaction timed out.
REQ-015 stray_cnt  output  8  saturating count of unexpected readdatavalid.
REQ-016 master_address  output  32  Avalon-MM address.
REQ-017 master_read  output  1  Avalon-MM read.
REQ-018 master_write  output  1  Avalon-MM write.
REQ-019 master_writedata  output  32  Avalon-MM write data.
REQ-020 master_byteenable  output  4  Avalon-MM byte enable.
REQ-021 master_waitrequest  input  1  slave stall.
REQ-022 master_readdata  input  32  slave read data.
REQ-023 master_readdatavalid  input  1  slave read data strobe.

Function
REQ-024 SHALL implement states IDLE, REQ, RD_WAIT, RSP; cmd_ready=1 only in IDLE.
REQ-025 Handshake cmd_valid&cmd_ready in cycle N SHALL register addr/wdata/type and enter REQ, with master_read or master_write high from cycle N+1.
REQ-026 In REQ, master_address/writedata/read/write SHALL stay stable while master_waitrequest=1; master_byteenable SHALL be 4'hF whenever a request is asserted, else 4'h0.
REQ-027 REQ completion = request high and waitrequest=0; request SHALL drop the following cycle (exactly one accepted beat).
REQ-028 Write completion SHALL enter RSP with rsp_rdata=0, rsp_timeout=0.
REQ-029 Read completion SHALL enter RD_WAIT, unless readdatavalid=1 in the same cycle, in which case readdata is captured and RSP entered directly.
REQ-030 In RD_WAIT, first readdatavalid SHALL capture master_readdata into rsp_rdata and enter RSP.
REQ-031 16-bit timeout counter SHALL clear on entry to REQ and increment each cycle in REQ/RD_WAIT; on reaching TIMEOUT_CYCLES without completion, request SHALL drop, rsp_timeout=1, rsp_rdata=TIMEOUT_DATA (reads) or 0 (writes), enter RSP.
REQ-032 In RSP, rsp_valid=1 and rsp_* SHALL hold until rsp_valid&rsp_ready; then IDLE next cycle (no same-cycle new command accept).
REQ-033 readdatavalid in IDLE, REQ-without-read-completion, or RSP SHALL be ignored for data and SHALL increment stray_cnt, saturating at 8'hFF; late data after a timeout counts as stray.
REQ-034 Completion and timeout in the same cycle SHALL resolve as completion (no timeout).

Reset
REQ-035 During rst_n=0: state IDLE, cmd_ready=0, all master_* outputs 0, rsp_valid=0, rsp_rdata=0, rsp_write=0, rsp_timeout=0, stray_cnt=0, timeout counter 0.
REQ-036 First rising edge after rst_n release SHALL set cmd_ready=1; reset mid-transaction SHALL abort it with no response.

Verification
REQ-037 Write addr 0x10, data 0x1234_5678, waitrequest=0 -> master_write one cycle at N+1, rsp_valid at N+2, rsp_write=1, rsp_timeout=0.
REQ-038 Read addr 0x04, waitrequest high 3 cycles, readdatavalid 2 cycles later with 0xA5A5_0001 -> address stable 4 cycles, rsp_rdata=0xA5A5_0001.
REQ-039 Read with no readdatavalid, TIMEOUT_CYCLES=8 -> request dropped, rsp_timeout=1, rsp_rdata=0xDEAD_BEEF; later readdatavalid -> stray_cnt=1.
REQ-040 rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0 until one cycle after handshake.
REQ-041 300 stray readdatavalid pulses in IDLE -> stray_cnt=8'hFF.
REQ-042 rst_n asserted while waitrequest=1 in REQ -> master_read=0 immediately, no rsp_valid after release.

Source files
------------

// File: rtl/avmm_csr_master_if.sv
// Command/response and Avalon-MM bus bundle for the CSR master.
interface avmm_csr_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_write;
    logic        rsp_timeout;

    logic [31:0] master_address;
    logic        master_read;
    logic        master_write;
    logic [31:0] master_writedata;
    logic [3:0]  master_byteenable;
    logic        master_waitrequest;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;

    // View from the CSR master itself.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  master_waitrequest, master_readdata, master_readdatavalid,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_timeout,
        output master_address, master_read, master_write, master_writedata,
        output master_byteenable
    );

    // View from the command source / Avalon slave side.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output master_waitrequest, master_readdata, master_readdatavalid,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_timeout,
        input  master_address, master_read, master_write, master_writedata,
        input  master_byteenable
    );
endinterface

// File: rtl/avmm_csr_master.sv
// Single-outstanding CSR master: turns one command into one Avalon-MM beat,
// waits for read data with a bounded timeout and returns one response.
//
// state   | meaning
// IDLE    | ready for a command (cmd_ready=1 once out of reset)
// REQ     | read/write request on the bus, waiting for waitrequest=0
// RD_WAIT | read accepted, waiting for readdatavalid
// RSP     | response presented, waiting for rsp_ready
module avmm_csr_master #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    avmm_csr_master_if.master         bus,
    output logic [7:0]                stray_cnt
);
    typedef enum logic [1:0] {IDLE, REQ, RD_WAIT, RSP} state_t;

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [3:0]  be_q, be_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_write_q, rsp_write_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [7:0]  stray_cnt_q, stray_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_last;
    logic        stray_hit;
    logic        rdv;

    assign rdv      = bus.master_readdatavalid;
    // Current cycle is the last one allowed in REQ/RD_WAIT.
    assign tmo_last = (tmo_cnt_q == (TIMEOUT_CYCLES - 16'd1));

    // Next-state and next-output computation.
    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        read_d        = read_q;
        write_d       = write_q;
        be_d          = be_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_write_d   = rsp_write_q;
        rsp_timeout_d = rsp_timeout_q;
        tmo_cnt_d     = tmo_cnt_q;
        stray_hit     = 1'b0;

        case (state_q)
            IDLE: begin
                stray_hit   = rdv;
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d     = REQ;
                    cmd_ready_d = 1'b0;
                    addr_d      = bus.cmd_addr;
                    wdata_d     = bus.cmd_wdata;
                    read_d      = !bus.cmd_write;
                    write_d     = bus.cmd_write;
                    be_d        = 4'hF;
                    rsp_write_d = bus.cmd_write;
                    tmo_cnt_d   = 16'd0;
                end
            end
            REQ: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                // Only a read completing this very cycle may consume readdatavalid.
                stray_hit = rdv && !(read_q && !bus.master_waitrequest);
                if (!bus.master_waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    be_d    = 4'h0;
                    if (write_q) begin
                        state_d       = RSP;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = 32'd0;
                        rsp_timeout_d = 1'b0;
                    end else if (rdv) begin
                        state_d       = RSP;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = bus.master_readdata;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end else if (tmo_last) begin
                    read_d        = 1'b0;
                    write_d       = 1'b0;
                    be_d          = 4'h0;
                    state_d       = RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = write_q ? 32'd0 : TIMEOUT_DATA;
                    rsp_timeout_d = 1'b1;
                end
            end
            RD_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                if (rdv) begin
                    state_d       = RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = bus.master_readdata;
                    rsp_timeout_d = 1'b0;
                end else if (tmo_last) begin
                    state_d       = RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = TIMEOUT_DATA;
                    rsp_timeout_d = 1'b1;
                end
            end
            RSP: begin
                stray_hit = rdv;
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stray_cnt_d = (stray_hit && (stray_cnt_q != 8'hFF)) ? stray_cnt_q + 8'd1
                                                            : stray_cnt_q;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            be_q          <= 4'h0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_write_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            stray_cnt_q   <= 8'd0;
            tmo_cnt_q     <= 16'd0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            read_q        <= read_d;
            write_q       <= write_d;
            be_q          <= be_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_write_q   <= rsp_write_d;
            rsp_timeout_q <= rsp_timeout_d;
            stray_cnt_q   <= stray_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign bus.cmd_ready         = cmd_ready_q;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_rdata         = rsp_rdata_q;
    assign bus.rsp_write         = rsp_write_q;
    assign bus.rsp_timeout       = rsp_timeout_q;
    assign bus.master_address    = addr_q;
    assign bus.master_read       = read_q;
    assign bus.master_write      = write_q;
    assign bus.master_writedata  = wdata_q;
    assign bus.master_byteenable = be_q;
    assign stray_cnt             = stray_cnt_q;
endmodule
